// File: rtl/gpu_pkg.sv
// Shared types and encodings for the per-core context memory arbiter.
package gpu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_A   = 2'd1,
    OWN_B   = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_A    = 2'b01;
  localparam logic [1:0] OWNER_B    = 2'b10;

  localparam logic CTX_A = 1'b0;
  localparam logic CTX_B = 1'b1;

  function automatic logic [1:0] owner_of(input arb_state_t s);
    case (s)
      OWN_A:   return OWNER_A;
      OWN_B:   return OWNER_B;
      default: return OWNER_NONE;
    endcase
  endfunction

endpackage

// File: rtl/context_mem_arbiter_ctx_mux.sv
// Per-thread 2:1 request mux toward memory and response demux back to the owning context.
module ctx_mux
  import gpu_pkg::*;
#(
  parameter int THREADS   = 4,
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
) (
  input  logic [1:0]                          sel,
  input  logic [THREADS-1:0]                  a_read_valid,
  input  logic [THREADS-1:0][ADDR_BITS-1:0]   a_read_address,
  output logic [THREADS-1:0]                  a_read_ready,
  output logic [THREADS-1:0][DATA_BITS-1:0]   a_read_data,
  input  logic [THREADS-1:0]                  a_write_valid,
  input  logic [THREADS-1:0][ADDR_BITS-1:0]   a_write_address,
  input  logic [THREADS-1:0][DATA_BITS-1:0]   a_write_data,
  output logic [THREADS-1:0]                  a_write_ready,
  input  logic [THREADS-1:0]                  b_read_valid,
  input  logic [THREADS-1:0][ADDR_BITS-1:0]   b_read_address,
  output logic [THREADS-1:0]                  b_read_ready,
  output logic [THREADS-1:0][DATA_BITS-1:0]   b_read_data,
  input  logic [THREADS-1:0]                  b_write_valid,
  input  logic [THREADS-1:0][ADDR_BITS-1:0]   b_write_address,
  input  logic [THREADS-1:0][DATA_BITS-1:0]   b_write_data,
  output logic [THREADS-1:0]                  b_write_ready,
  output logic [THREADS-1:0]                  mem_read_valid,
  output logic [THREADS-1:0][ADDR_BITS-1:0]   mem_read_address,
  input  logic [THREADS-1:0]                  mem_read_ready,
  input  logic [THREADS-1:0][DATA_BITS-1:0]   mem_read_data,
  output logic [THREADS-1:0]                  mem_write_valid,
  output logic [THREADS-1:0][ADDR_BITS-1:0]   mem_write_address,
  output logic [THREADS-1:0][DATA_BITS-1:0]   mem_write_data,
  input  logic [THREADS-1:0]                  mem_write_ready
);

  // With no owner every valid and ready is forced low, which also covers the turnaround cycle.
  always_comb begin
    mem_read_valid    = '0;
    mem_read_address  = '0;
    mem_write_valid   = '0;
    mem_write_address = '0;
    mem_write_data    = '0;
    a_read_ready      = '0;
    a_read_data       = '0;
    a_write_ready     = '0;
    b_read_ready      = '0;
    b_read_data       = '0;
    b_write_ready     = '0;
    case (sel)
      OWNER_A: begin
        mem_read_valid    = a_read_valid;
        mem_read_address  = a_read_address;
        mem_write_valid   = a_write_valid;
        mem_write_address = a_write_address;
        mem_write_data    = a_write_data;
        a_read_ready      = mem_read_ready;
        a_read_data       = mem_read_data;
        a_write_ready     = mem_write_ready;
      end
      OWNER_B: begin
        mem_read_valid    = b_read_valid;
        mem_read_address  = b_read_address;
        mem_write_valid   = b_write_valid;
        mem_write_address = b_write_address;
        mem_write_data    = b_write_data;
        b_read_ready      = mem_read_ready;
        b_read_data       = mem_read_data;
        b_write_ready     = mem_write_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/context_mem_arbiter.sv
// Shares one set of per-thread data-memory channels between context A and context B LSU banks.
//   state   | meaning
//   IDLE    | bus free, waiting for a request (alternating grant on contention)
//   OWN_A   | context A owns the bus until all its threads go quiet
//   OWN_B   | context B owns the bus until all its threads go quiet
//   RELEASE | one turnaround cycle with every memory valid low
module context_mem_arbiter
  import gpu_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int ADDR_BITS         = 8,
  parameter int DATA_BITS         = 8,
  parameter int CNT_BITS          = 16
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic [THREADS_PER_BLOCK-1:0]                    a_read_valid,
  input  logic [THREADS_PER_BLOCK-1:0][ADDR_BITS-1:0]     a_read_address,
  output logic [THREADS_PER_BLOCK-1:0]                    a_read_ready,
  output logic [THREADS_PER_BLOCK-1:0][DATA_BITS-1:0]     a_read_data,
  input  logic [THREADS_PER_BLOCK-1:0]                    a_write_valid,
  input  logic [THREADS_PER_BLOCK-1:0][ADDR_BITS-1:0]     a_write_address,
  input  logic [THREADS_PER_BLOCK-1:0][DATA_BITS-1:0]     a_write_data,
  output logic [THREADS_PER_BLOCK-1:0]                    a_write_ready,
  input  logic [THREADS_PER_BLOCK-1:0]                    b_read_valid,
  input  logic [THREADS_PER_BLOCK-1:0][ADDR_BITS-1:0]     b_read_address,
  output logic [THREADS_PER_BLOCK-1:0]                    b_read_ready,
  output logic [THREADS_PER_BLOCK-1:0][DATA_BITS-1:0]     b_read_data,
  input  logic [THREADS_PER_BLOCK-1:0]                    b_write_valid,
  input  logic [THREADS_PER_BLOCK-1:0][ADDR_BITS-1:0]     b_write_address,
  input  logic [THREADS_PER_BLOCK-1:0][DATA_BITS-1:0]     b_write_data,
  output logic [THREADS_PER_BLOCK-1:0]                    b_write_ready,
  output logic [THREADS_PER_BLOCK-1:0]                    mem_read_valid,
  output logic [THREADS_PER_BLOCK-1:0][ADDR_BITS-1:0]     mem_read_address,
  input  logic [THREADS_PER_BLOCK-1:0]                    mem_read_ready,
  input  logic [THREADS_PER_BLOCK-1:0][DATA_BITS-1:0]     mem_read_data,
  output logic [THREADS_PER_BLOCK-1:0]                    mem_write_valid,
  output logic [THREADS_PER_BLOCK-1:0][ADDR_BITS-1:0]     mem_write_address,
  output logic [THREADS_PER_BLOCK-1:0][DATA_BITS-1:0]     mem_write_data,
  input  logic [THREADS_PER_BLOCK-1:0]                    mem_write_ready,
  output logic [1:0]                                      bus_owner,
  output logic                                            busy_for_a,
  output logic                                            busy_for_b,
  output logic [CNT_BITS-1:0]                             contention_count
);

  logic       req_a;
  logic       req_b;
  logic       last_grant;
  logic       contend;
  arb_state_t state;
  arb_state_t state_next;

  assign req_a = |{a_read_valid, a_write_valid};
  assign req_b = |{b_read_valid, b_write_valid};

  always_comb begin
    state_next = state;
    contend    = 1'b0;
    case (state)
      IDLE: begin
        if (req_a && req_b) begin
          contend    = 1'b1;
          state_next = (last_grant == CTX_B) ? OWN_A : OWN_B;
        end else if (req_a) begin
          state_next = OWN_A;
        end else if (req_b) begin
          state_next = OWN_B;
        end
      end
      OWN_A:   if (!req_a) state_next = RELEASE;
      OWN_B:   if (!req_b) state_next = RELEASE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they always mirror the current state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      last_grant       <= CTX_B;
      contention_count <= '0;
      bus_owner        <= OWNER_NONE;
      busy_for_a       <= 1'b0;
      busy_for_b       <= 1'b0;
    end else begin
      state      <= state_next;
      bus_owner  <= owner_of(state_next);
      busy_for_a <= (state_next == OWN_B);
      busy_for_b <= (state_next == OWN_A);
      if (state == OWN_A && !req_a) last_grant <= CTX_A;
      if (state == OWN_B && !req_b) last_grant <= CTX_B;
      if (contend && contention_count != '1)
        contention_count <= contention_count + CNT_BITS'(1);
    end
  end

  ctx_mux #(
    .THREADS   (THREADS_PER_BLOCK),
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS)
  ) u_ctx_mux (
    .sel               (bus_owner),
    .a_read_valid      (a_read_valid),
    .a_read_address    (a_read_address),
    .a_read_ready      (a_read_ready),
    .a_read_data       (a_read_data),
    .a_write_valid     (a_write_valid),
    .a_write_address   (a_write_address),
    .a_write_data      (a_write_data),
    .a_write_ready     (a_write_ready),
    .b_read_valid      (b_read_valid),
    .b_read_address    (b_read_address),
    .b_read_ready      (b_read_ready),
    .b_read_data       (b_read_data),
    .b_write_valid     (b_write_valid),
    .b_write_address   (b_write_address),
    .b_write_data      (b_write_data),
    .b_write_ready     (b_write_ready),
    .mem_read_valid    (mem_read_valid),
    .mem_read_address  (mem_read_address),
    .mem_read_ready    (mem_read_ready),
    .mem_read_data     (mem_read_data),
    .mem_write_valid   (mem_write_valid),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .mem_write_ready   (mem_write_ready)
  );

endmodule

// File: tb/tb_context_mem_arbiter.sv
// Randomized and directed checks of context_mem_arbiter against an ownership model.
module tb_context_mem_arbiter;
  localparam int T = 4, AW = 8, DW = 8, CW = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [T-1:0]         a_read_valid, a_write_valid, b_read_valid, b_write_valid;
  logic [T-1:0][AW-1:0] a_read_address, a_write_address, b_read_address, b_write_address;
  logic [T-1:0][DW-1:0] a_write_data, b_write_data;
  logic [T-1:0]         mem_read_ready, mem_write_ready;
  logic [T-1:0][DW-1:0] mem_read_data;

  logic [T-1:0]         a_read_ready, a_write_ready, b_read_ready, b_write_ready;
  logic [T-1:0][DW-1:0] a_read_data, b_read_data;
  logic [T-1:0]         mem_read_valid, mem_write_valid;
  logic [T-1:0][AW-1:0] mem_read_address, mem_write_address;
  logic [T-1:0][DW-1:0] mem_write_data;
  logic [1:0]           bus_owner;
  logic                 busy_for_a, busy_for_b;
  logic [CW-1:0]        contention_count;

  logic [T-1:0]         d2_a_read_ready, d2_a_write_ready, d2_b_read_ready, d2_b_write_ready;
  logic [T-1:0][DW-1:0] d2_a_read_data, d2_b_read_data;
  logic [T-1:0]         d2_mem_read_valid, d2_mem_write_valid;
  logic [T-1:0][AW-1:0] d2_mem_read_address, d2_mem_write_address;
  logic [T-1:0][DW-1:0] d2_mem_write_data;
  logic [1:0]           d2_bus_owner;
  logic                 d2_busy_for_a, d2_busy_for_b;
  logic [1:0]           d2_contention_count;

  context_mem_arbiter #(.THREADS_PER_BLOCK(T), .ADDR_BITS(AW), .DATA_BITS(DW), .CNT_BITS(CW)) dut (
    .clk(clk), .reset(reset),
    .a_read_valid(a_read_valid), .a_read_address(a_read_address), .a_read_ready(a_read_ready),
    .a_read_data(a_read_data), .a_write_valid(a_write_valid), .a_write_address(a_write_address),
    .a_write_data(a_write_data), .a_write_ready(a_write_ready),
    .b_read_valid(b_read_valid), .b_read_address(b_read_address), .b_read_ready(b_read_ready),
    .b_read_data(b_read_data), .b_write_valid(b_write_valid), .b_write_address(b_write_address),
    .b_write_data(b_write_data), .b_write_ready(b_write_ready),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address), .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data), .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
    .bus_owner(bus_owner), .busy_for_a(busy_for_a), .busy_for_b(busy_for_b),
    .contention_count(contention_count)
  );

  // Narrow-counter instance sharing all stimulus, used to observe saturation.
  context_mem_arbiter #(.THREADS_PER_BLOCK(T), .ADDR_BITS(AW), .DATA_BITS(DW), .CNT_BITS(2)) dut_sat (
    .clk(clk), .reset(reset),
    .a_read_valid(a_read_valid), .a_read_address(a_read_address), .a_read_ready(d2_a_read_ready),
    .a_read_data(d2_a_read_data), .a_write_valid(a_write_valid), .a_write_address(a_write_address),
    .a_write_data(a_write_data), .a_write_ready(d2_a_write_ready),
    .b_read_valid(b_read_valid), .b_read_address(b_read_address), .b_read_ready(d2_b_read_ready),
    .b_read_data(d2_b_read_data), .b_write_valid(b_write_valid), .b_write_address(b_write_address),
    .b_write_data(b_write_data), .b_write_ready(d2_b_write_ready),
    .mem_read_valid(d2_mem_read_valid), .mem_read_address(d2_mem_read_address), .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data), .mem_write_valid(d2_mem_write_valid), .mem_write_address(d2_mem_write_address),
    .mem_write_data(d2_mem_write_data), .mem_write_ready(mem_write_ready),
    .bus_owner(d2_bus_owner), .busy_for_a(d2_busy_for_a), .busy_for_b(d2_busy_for_b),
    .contention_count(d2_contention_count)
  );

  int n_cmp = 0, n_err = 0;

  // Model: m_state 0 free, 1 A owns, 2 B owns, 3 turnaround; m_last is the last owner to release (1 A, 2 B).
  int m_state, m_last, m_cnt;

  task automatic model_reset();
    m_state = 0; m_last = 2; m_cnt = 0;
  endtask

  task automatic model_edge(input bit ra, input bit rb);
    case (m_state)
      0: if (ra && rb) begin m_state = (m_last == 2) ? 1 : 2; m_cnt++; end
         else if (ra) m_state = 1;
         else if (rb) m_state = 2;
      1: if (!ra) begin m_state = 3; m_last = 1; end
      2: if (!rb) begin m_state = 3; m_last = 2; end
      default: m_state = 0;
    endcase
  endtask

  function automatic logic [1:0] exp_owner();
    return (m_state == 1) ? 2'b01 : (m_state == 2) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [CW-1:0] exp_cnt16();
    return (m_cnt > 65535) ? 16'hFFFF : CW'(m_cnt);
  endfunction

  function automatic logic [1:0] exp_cnt2();
    return (m_cnt > 3) ? 2'd3 : 2'(m_cnt);
  endfunction

  task automatic step();
    bit ra, rb;
    ra = |{a_read_valid, a_write_valid};
    rb = |{b_read_valid, b_write_valid};
    @(posedge clk);
    model_edge(ra, rb);
    #1;
  endtask

  task automatic clear_inputs();
    a_read_valid = '0; a_read_address = '0; a_write_valid = '0; a_write_address = '0; a_write_data = '0;
    b_read_valid = '0; b_read_address = '0; b_write_valid = '0; b_write_address = '0; b_write_data = '0;
    mem_read_ready = '0; mem_read_data = '0; mem_write_ready = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    model_reset();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    n_cmp++; if (bus_owner !== 2'b00) begin n_err++; $display("FAIL reset_owner got=%b exp=00", bus_owner); end
    a_read_valid = 4'hF; mem_read_ready = 4'hF;
    step();
    n_cmp++; if (bus_owner !== 2'b01) begin n_err++; $display("FAIL reset_grant_a got=%b exp=01", bus_owner); end
    n_cmp++; if (mem_read_valid !== 4'hF) begin n_err++; $display("FAIL reset_pre_valid got=%h exp=f", mem_read_valid); end
    #3 reset = 1'b0;
    #1;
    n_cmp++; if (mem_read_valid !== 4'h0) begin n_err++; $display("FAIL reset_async_valid got=%h exp=0", mem_read_valid); end
    n_cmp++; if (bus_owner !== 2'b00) begin n_err++; $display("FAIL reset_async_owner got=%b exp=00", bus_owner); end
    n_cmp++; if (contention_count !== '0) begin n_err++; $display("FAIL reset_async_cnt got=%0d exp=0", contention_count); end
    n_cmp++; if (a_read_ready !== 4'h0) begin n_err++; $display("FAIL reset_async_ready got=%h exp=0", a_read_ready); end
    model_reset();
    #2 reset = 1'b1;
    step();
    n_cmp++; if (bus_owner !== 2'b01) begin n_err++; $display("FAIL reset_regrant got=%b exp=01", bus_owner); end
    a_read_valid = '0; mem_read_ready = '0;
    step(); step();
  endtask

  task automatic test_single_requester();
    clear_inputs();
    a_read_valid = 4'b0100; a_read_address = 32'h113C2233;
    step();
    n_cmp++; if (bus_owner !== 2'b01) begin n_err++; $display("FAIL single_owner got=%b exp=01", bus_owner); end
    n_cmp++; if (mem_read_valid !== 4'b0100) begin n_err++; $display("FAIL single_valid got=%b exp=0100", mem_read_valid); end
    n_cmp++; if (mem_read_address[2] !== 8'h3C) begin n_err++; $display("FAIL single_addr got=%h exp=3c", mem_read_address[2]); end
    repeat (2) begin
      step();
      n_cmp++; if (a_read_ready !== 4'b0000) begin n_err++; $display("FAIL single_early_ready got=%b exp=0000", a_read_ready); end
    end
    mem_read_ready = 4'b0100; mem_read_data[2] = 8'h5A;
    #1;
    n_cmp++; if (a_read_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready got=%b exp=0100", a_read_ready); end
    n_cmp++; if (a_read_data[2] !== 8'h5A) begin n_err++; $display("FAIL single_data got=%h exp=5a", a_read_data[2]); end
    n_cmp++; if (b_read_ready !== 4'b0000) begin n_err++; $display("FAIL single_b_ready got=%b exp=0000", b_read_ready); end
    n_cmp++; if (b_read_data !== '0) begin n_err++; $display("FAIL single_b_data got=%h exp=0", b_read_data); end
    step();
    a_read_valid = '0; mem_read_ready = '0;
    step();
    n_cmp++; if (bus_owner !== 2'b00 || mem_read_valid !== 4'h0) begin n_err++; $display("FAIL single_release owner=%b valid=%b exp=00/0000", bus_owner, mem_read_valid); end
    step();
    n_cmp++; if (bus_owner !== exp_owner()) begin n_err++; $display("FAIL single_idle got=%b exp=%b", bus_owner, exp_owner()); end
  endtask

  task automatic test_contention();
    clear_inputs();
    do_reset();
    a_read_valid = 4'b0001; a_read_address[0] = 8'h11;
    b_read_valid = 4'b0010; b_read_address[1] = 8'h22;
    step();
    n_cmp++; if (bus_owner !== 2'b01) begin n_err++; $display("FAIL cont_first got=%b exp=01", bus_owner); end
    n_cmp++; if (contention_count !== 16'd1) begin n_err++; $display("FAIL cont_cnt got=%0d exp=1", contention_count); end
    n_cmp++; if (mem_read_address[0] !== 8'h11 || mem_read_valid !== 4'b0001) begin n_err++; $display("FAIL cont_a_bus addr=%h valid=%b exp=11/0001", mem_read_address[0], mem_read_valid); end
    n_cmp++; if (busy_for_b !== 1'b1 || busy_for_a !== 1'b0) begin n_err++; $display("FAIL cont_busy a=%b b=%b exp=0/1", busy_for_a, busy_for_b); end
    mem_read_ready = 4'b0001;
    step();
    a_read_valid = '0; mem_read_ready = '0;
    step();
    n_cmp++; if (bus_owner !== 2'b00) begin n_err++; $display("FAIL cont_release got=%b exp=00", bus_owner); end
    step();
    n_cmp++; if (bus_owner !== 2'b00) begin n_err++; $display("FAIL cont_idle_gap got=%b exp=00", bus_owner); end
    step();
    n_cmp++; if (bus_owner !== 2'b10) begin n_err++; $display("FAIL cont_second got=%b exp=10", bus_owner); end
    n_cmp++; if (mem_read_address[1] !== 8'h22 || mem_read_valid !== 4'b0010) begin n_err++; $display("FAIL cont_b_bus addr=%h valid=%b exp=22/0010", mem_read_address[1], mem_read_valid); end
    n_cmp++; if (busy_for_a !== 1'b1) begin n_err++; $display("FAIL cont_busy_a got=%b exp=1", busy_for_a); end
    b_read_valid = '0;
    step(); step();
  endtask

  task automatic test_back_to_back();
    logic [1:0] eo;
    clear_inputs();
    do_reset();
    a_read_valid = 4'b1000; b_write_valid = 4'b0001;
    for (int r = 0; r < 5; r++) begin
      step();
      eo = (r % 2 == 0) ? 2'b01 : 2'b10;
      n_cmp++; if (bus_owner !== eo) begin n_err++; $display("FAIL b2b_owner round=%0d got=%b exp=%b", r, bus_owner, eo); end
      n_cmp++; if (busy_for_b !== (eo == 2'b01) || busy_for_a !== (eo == 2'b10)) begin n_err++; $display("FAIL b2b_busy round=%0d a=%b b=%b", r, busy_for_a, busy_for_b); end
      n_cmp++; if (contention_count !== CW'(r + 1)) begin n_err++; $display("FAIL b2b_cnt round=%0d got=%0d exp=%0d", r, contention_count, r + 1); end
      n_cmp++; if (d2_contention_count !== exp_cnt2()) begin n_err++; $display("FAIL b2b_sat round=%0d got=%0d exp=%0d", r, d2_contention_count, exp_cnt2()); end
      if (eo == 2'b01) a_read_valid = '0; else b_write_valid = '0;
      step();
      n_cmp++; if (bus_owner !== 2'b00 || busy_for_b !== 1'b0) begin n_err++; $display("FAIL b2b_release round=%0d owner=%b busy_b=%b", r, bus_owner, busy_for_b); end
      a_read_valid = 4'b1000; b_write_valid = 4'b0001;
      step();
    end
    n_cmp++; if (d2_contention_count !== 2'd3) begin n_err++; $display("FAIL sat_hold got=%0d exp=3", d2_contention_count); end
    clear_inputs();
    step();
  endtask

  task automatic test_extended_ownership();
    clear_inputs();
    do_reset();
    n_cmp++; if (contention_count !== '0 || d2_contention_count !== 2'd0) begin n_err++; $display("FAIL ext_cnt_cleared got=%0d/%0d exp=0/0", contention_count, d2_contention_count); end
    a_read_valid = 4'b0001;
    step();
    b_write_valid = 4'b0001; b_write_address[0] = 8'h55;
    mem_read_ready = 4'b0001;
    step();
    a_read_valid = '0; mem_read_ready = '0;
    a_write_valid = 4'b1000; a_write_address[3] = 8'h10; a_write_data[3] = 8'h77;
    #1;
    n_cmp++; if (mem_write_valid !== 4'b1000) begin n_err++; $display("FAIL ext_wvalid got=%b exp=1000", mem_write_valid); end
    n_cmp++; if (mem_write_address[3] !== 8'h10 || mem_write_data[3] !== 8'h77) begin n_err++; $display("FAIL ext_wpayload addr=%h data=%h exp=10/77", mem_write_address[3], mem_write_data[3]); end
    repeat (2) begin
      step();
      n_cmp++; if (bus_owner !== 2'b01 || busy_for_b !== 1'b1) begin n_err++; $display("FAIL ext_retain owner=%b busy_b=%b exp=01/1", bus_owner, busy_for_b); end
    end
    mem_write_ready = 4'b1000;
    #1;
    n_cmp++; if (a_write_ready !== 4'b1000 || b_write_ready !== 4'b0000) begin n_err++; $display("FAIL ext_wready a=%b b=%b exp=1000/0000", a_write_ready, b_write_ready); end
    step();
    a_write_valid = '0; mem_write_ready = '0;
    step();
    n_cmp++; if (busy_for_b !== 1'b0) begin n_err++; $display("FAIL ext_release_busy got=%b exp=0", busy_for_b); end
    step(); step();
    n_cmp++; if (bus_owner !== 2'b10 || mem_write_valid !== 4'b0001 || mem_write_address[0] !== 8'h55) begin n_err++; $display("FAIL ext_b_owns owner=%b valid=%b addr=%h", bus_owner, mem_write_valid, mem_write_address[0]); end
    b_write_valid = '0;
    step(); step();
  endtask

  task automatic test_random();
    logic [1:0]   eo;
    logic [T-1:0] erv, ewv;
    clear_inputs();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      a_read_valid  = 4'($urandom & $urandom & $urandom);
      a_write_valid = 4'($urandom & $urandom & $urandom);
      b_read_valid  = 4'($urandom & $urandom & $urandom);
      b_write_valid = 4'($urandom & $urandom & $urandom);
      a_read_address = $urandom; a_write_address = $urandom; a_write_data = $urandom;
      b_read_address = $urandom; b_write_address = $urandom; b_write_data = $urandom;
      mem_read_ready = 4'($urandom); mem_write_ready = 4'($urandom); mem_read_data = $urandom;
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b0;
        #1;
        n_cmp++; if (mem_read_valid !== '0 || mem_write_valid !== '0 || bus_owner !== 2'b00) begin n_err++; $display("FAIL rnd_async_reset cyc=%0d rv=%b wv=%b owner=%b", c, mem_read_valid, mem_write_valid, bus_owner); end
        model_reset();
        reset = 1'b1;
      end
      #1;
      eo  = exp_owner();
      erv = (eo == 2'b01) ? a_read_valid  : (eo == 2'b10) ? b_read_valid  : '0;
      ewv = (eo == 2'b01) ? a_write_valid : (eo == 2'b10) ? b_write_valid : '0;
      n_cmp++; if (bus_owner !== eo) begin n_err++; $display("FAIL rnd_owner cyc=%0d got=%b exp=%b", c, bus_owner, eo); end
      n_cmp++; if (busy_for_a !== (m_state == 2) || busy_for_b !== (m_state == 1)) begin n_err++; $display("FAIL rnd_busy cyc=%0d a=%b b=%b model=%0d", c, busy_for_a, busy_for_b, m_state); end
      n_cmp++; if (contention_count !== exp_cnt16()) begin n_err++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", c, contention_count, exp_cnt16()); end
      n_cmp++; if (d2_contention_count !== exp_cnt2()) begin n_err++; $display("FAIL rnd_sat cyc=%0d got=%0d exp=%0d", c, d2_contention_count, exp_cnt2()); end
      n_cmp++; if (mem_read_valid !== erv || mem_write_valid !== ewv) begin n_err++; $display("FAIL rnd_valid cyc=%0d rv=%b/%b wv=%b/%b", c, mem_read_valid, erv, mem_write_valid, ewv); end
      if (eo == 2'b01) begin
        n_cmp++; if (mem_read_address !== a_read_address || mem_write_address !== a_write_address || mem_write_data !== a_write_data) begin n_err++; $display("FAIL rnd_a_payload cyc=%0d ra=%h wa=%h wd=%h", c, mem_read_address, mem_write_address, mem_write_data); end
      end else if (eo == 2'b10) begin
        n_cmp++; if (mem_read_address !== b_read_address || mem_write_address !== b_write_address || mem_write_data !== b_write_data) begin n_err++; $display("FAIL rnd_b_payload cyc=%0d ra=%h wa=%h wd=%h", c, mem_read_address, mem_write_address, mem_write_data); end
      end
      n_cmp++; if (a_read_ready !== ((eo == 2'b01) ? mem_read_ready : '0) || a_write_ready !== ((eo == 2'b01) ? mem_write_ready : '0)) begin n_err++; $display("FAIL rnd_a_ready cyc=%0d r=%b w=%b", c, a_read_ready, a_write_ready); end
      n_cmp++; if (b_read_ready !== ((eo == 2'b10) ? mem_read_ready : '0) || b_write_ready !== ((eo == 2'b10) ? mem_write_ready : '0)) begin n_err++; $display("FAIL rnd_b_ready cyc=%0d r=%b w=%b", c, b_read_ready, b_write_ready); end
      n_cmp++; if (a_read_data !== ((eo == 2'b01) ? mem_read_data : '0)) begin n_err++; $display("FAIL rnd_a_data cyc=%0d got=%h", c, a_read_data); end
      n_cmp++; if (b_read_data !== ((eo == 2'b10) ? mem_read_data : '0)) begin n_err++; $display("FAIL rnd_b_data cyc=%0d got=%h", c, b_read_data); end
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_requester();
    test_contention();
    test_back_to_back();
    test_extended_ownership();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
